spi_shift_register: RTL and testbench

- Serial data engine directly downstream of the SPI baud-rate generator.
- Consumes the generator's MOSI-send and MISO-receive strobes (both rising- and falling-edge variants).
- Serialises a parallel transmit byte onto mosi_o and assembles sampled miso_i bits into a parallel receive word.
- Signals completion to the APB slave interface with a single-cycle pulse.

---
 rtl/spi_shift_register_pkg.sv | 17 +
 rtl/spi_shift_register_if.sv | 40 ++++
 rtl/spi_shift_register.sv | 115 +++++++++++
 tb/tb_spi_shift_register.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_shift_register_pkg.sv
// Shared types and helpers for the SPI serial data engine.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam int unsigned DATA_W_DEF = 8;

  // 1 selects the rising-edge strobe set (SPI modes 0 and 3).
  function automatic logic sel_edge(input logic cpol, input logic cpha);
    return cpol == cpha;
  endfunction

endpackage

// File: rtl/spi_shift_register_if.sv
// Signal bundle between the baud generator / APB side and the shift engine.
interface spi_shift_register_if
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              ss_i;
  logic              send_data_i;
  logic              lsbfe_i;
  logic              cpol_i;
  logic              cpha_i;
  logic              mosi_send_sclk_i;
  logic              mosi_send_sclk0_i;
  logic              miso_receive_sclk_i;
  logic              miso_receive_sclk0_i;
  logic [DATA_W-1:0] data_mosi_i;
  logic              miso_i;
  logic              mosi_o;
  logic [DATA_W-1:0] data_miso_o;
  logic              receive_data_o;
  logic              busy_o;

  modport slave (
    input  ss_i, send_data_i, lsbfe_i, cpol_i, cpha_i,
    input  mosi_send_sclk_i, mosi_send_sclk0_i,
    input  miso_receive_sclk_i, miso_receive_sclk0_i,
    input  data_mosi_i, miso_i,
    output mosi_o, data_miso_o, receive_data_o, busy_o
  );

  modport master (
    output ss_i, send_data_i, lsbfe_i, cpol_i, cpha_i,
    output mosi_send_sclk_i, mosi_send_sclk0_i,
    output miso_receive_sclk_i, miso_receive_sclk0_i,
    output data_mosi_i, miso_i,
    input  mosi_o, data_miso_o, receive_data_o, busy_o
  );

endinterface

// File: rtl/spi_shift_register.sv
// SPI serial data engine: serialises a transmit word on mosi_o and assembles
// sampled miso_i bits into a receive word, timed by baud-generator strobes.
module spi_shift_register
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input logic                 PCLK,
  input logic                 PRESET,
  spi_shift_register_if.slave bus
);

  localparam int unsigned   CW   = $clog2(DATA_W + 1);
  localparam int unsigned   IW   = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] data_miso_q, data_miso_d;
  logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
  logic              lsb_q, lsb_d;
  logic              mosi_q, mosi_d;
  logic              snd, smp;
  logic [IW-1:0]     tx_idx, rx_idx;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      data_miso_q <= '0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      lsb_q       <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      data_miso_q <= data_miso_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      lsb_q       <= lsb_d;
      mosi_q      <= mosi_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    data_miso_d = data_miso_q;
    tx_cnt_d    = tx_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    lsb_d       = lsb_q;
    mosi_d      = mosi_q;

    snd = sel_edge(bus.cpol_i, bus.cpha_i) ? bus.mosi_send_sclk_i    : bus.mosi_send_sclk0_i;
    smp = sel_edge(bus.cpol_i, bus.cpha_i) ? bus.miso_receive_sclk_i : bus.miso_receive_sclk0_i;

    // Index is only meaningful while the count is below DATA_W.
    tx_idx = IW'(lsb_q ? tx_cnt_q : (LAST - CW'(1) - tx_cnt_q));
    rx_idx = IW'(lsb_q ? rx_cnt_q : (LAST - CW'(1) - rx_cnt_q));

    unique case (state_q)
      IDLE: begin
        mosi_d = 1'b0;
        if (bus.send_data_i && !bus.ss_i) begin
          tx_sr_d  = bus.data_mosi_i;
          rx_sr_d  = '0;
          lsb_d    = bus.lsbfe_i;
          tx_cnt_d = '0;
          rx_cnt_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.ss_i) begin
          mosi_d   = 1'b0;
          tx_cnt_d = '0;
          rx_cnt_d = '0;
          state_d  = IDLE;
        end else begin
          if (snd && (tx_cnt_q < LAST)) begin
            mosi_d   = tx_sr_q[tx_idx];
            tx_cnt_d = tx_cnt_q + CW'(1);
          end
          if (smp && (rx_cnt_q < LAST)) begin
            rx_sr_d[rx_idx] = bus.miso_i;
            rx_cnt_d        = rx_cnt_q + CW'(1);
            // Publish the word on the same edge that enters DONE so it is
            // already valid while receive_data_o is high.
            if (rx_cnt_q == LAST - CW'(1)) begin
              data_miso_d = rx_sr_d;
              state_d     = DONE;
            end
          end
        end
      end
      DONE: begin
        mosi_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mosi_o         = mosi_q;
  assign bus.data_miso_o    = data_miso_q;
  assign bus.receive_data_o = (state_q == DONE);
  assign bus.busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_spi_shift_register.sv
// Directed self-checking bench for spi_shift_register (DATA_W = 8).
module tb_spi_shift_register;

  logic PCLK = 1'b0;
  logic PRESET;
  int   checks = 0;
  int   failures = 0;

  always #5 PCLK = ~PCLK;

  spi_shift_register_if #(.DATA_W(8)) bus ();

  spi_shift_register #(.DATA_W(8)) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .bus   (bus)
  );

  task automatic cyc(input logic sr, input logic mr, input logic sf, input logic mf, input logic mi);
    bus.mosi_send_sclk_i     = sr;
    bus.miso_receive_sclk_i  = mr;
    bus.mosi_send_sclk0_i    = sf;
    bus.miso_receive_sclk0_i = mf;
    bus.miso_i               = mi;
    @(posedge PCLK); #1;
    bus.mosi_send_sclk_i     = 1'b0;
    bus.miso_receive_sclk_i  = 1'b0;
    bus.mosi_send_sclk0_i    = 1'b0;
    bus.miso_receive_sclk0_i = 1'b0;
  endtask

  task automatic start(input logic [7:0] d, input logic lsb);
    bus.ss_i        = 1'b0;
    bus.data_mosi_i = d;
    bus.lsbfe_i     = lsb;
    bus.send_data_i = 1'b1;
    @(posedge PCLK); #1;
    bus.send_data_i = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    checks++; if (bus.mosi_o !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b exp=0", bus.mosi_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
    checks++; if (bus.receive_data_o !== 1'b0) begin failures++; $display("FAIL reset_rcv got=%b exp=0", bus.receive_data_o); end
    checks++; if (bus.data_miso_o !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", bus.data_miso_o); end
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(posedge PCLK); #1;
  endtask

  task automatic test_msb_mode0;
    logic [7:0] txw = 8'hA5;
    logic [7:0] rxw = 8'h3C;
    bus.cpol_i = 1'b0; bus.cpha_i = 1'b0;
    start(txw, 1'b0);
    checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL m0_busy_start got=%b exp=1", bus.busy_o); end
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (bus.mosi_o !== txw[7-k]) begin failures++; $display("FAIL m0_mosi bit%0d got=%b exp=%b", k, bus.mosi_o, txw[7-k]); end
      cyc(1'b0, 1'b1, 1'b0, 1'b0, rxw[7-k]);
      if (k < 7) begin
        checks++; if (bus.receive_data_o !== 1'b0) begin failures++; $display("FAIL m0_rcv_early bit%0d got=%b exp=0", k, bus.receive_data_o); end
      end
    end
    checks++; if (bus.receive_data_o !== 1'b1) begin failures++; $display("FAIL m0_rcv got=%b exp=1", bus.receive_data_o); end
    checks++; if (bus.data_miso_o !== 8'h3C) begin failures++; $display("FAIL m0_data got=%h exp=3c", bus.data_miso_o); end
    checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL m0_busy_done got=%b exp=1", bus.busy_o); end
    @(posedge PCLK); #1;
    checks++; if (bus.receive_data_o !== 1'b0) begin failures++; $display("FAIL m0_rcv_after got=%b exp=0", bus.receive_data_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL m0_busy_after got=%b exp=0", bus.busy_o); end
    checks++; if (bus.mosi_o !== 1'b0) begin failures++; $display("FAIL m0_mosi_after got=%b exp=0", bus.mosi_o); end
  endtask

  task automatic test_abort;
    bus.cpol_i = 1'b0; bus.cpha_i = 1'b0;
    start(8'h99, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    bus.ss_i = 1'b1;
    @(posedge PCLK); #1;
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL ab_busy got=%b exp=0", bus.busy_o); end
    checks++; if (bus.mosi_o !== 1'b0) begin failures++; $display("FAIL ab_mosi got=%b exp=0", bus.mosi_o); end
    checks++; if (bus.receive_data_o !== 1'b0) begin failures++; $display("FAIL ab_rcv got=%b exp=0", bus.receive_data_o); end
    checks++; if (bus.data_miso_o !== 8'h3C) begin failures++; $display("FAIL ab_data got=%h exp=3c", bus.data_miso_o); end
    @(posedge PCLK); #1;
    checks++; if (bus.receive_data_o !== 1'b0) begin failures++; $display("FAIL ab_rcv_late got=%b exp=0", bus.receive_data_o); end
    bus.ss_i = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL ab_idle_strobe_busy got=%b exp=0", bus.busy_o); end
    checks++; if (bus.data_miso_o !== 8'h3C) begin failures++; $display("FAIL ab_idle_strobe_data got=%h exp=3c", bus.data_miso_o); end
  endtask

  task automatic test_lsb_mode10;
    logic [7:0] txw = 8'h0F;
    logic [7:0] rxw = 8'hF0;
    logic       prev;
    bus.cpol_i = 1'b1; bus.cpha_i = 1'b0;
    start(txw, 1'b1);
    prev = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, ~rxw[k]);
      checks++; if (bus.mosi_o !== prev) begin failures++; $display("FAIL m2_inject bit%0d got=%b exp=%b", k, bus.mosi_o, prev); end
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++; if (bus.mosi_o !== txw[k]) begin failures++; $display("FAIL m2_mosi bit%0d got=%b exp=%b", k, bus.mosi_o, txw[k]); end
      prev = txw[k];
      cyc(1'b0, 1'b0, 1'b0, 1'b1, rxw[k]);
    end
    checks++; if (bus.receive_data_o !== 1'b1) begin failures++; $display("FAIL m2_rcv got=%b exp=1", bus.receive_data_o); end
    checks++; if (bus.data_miso_o !== 8'hF0) begin failures++; $display("FAIL m2_data got=%h exp=f0", bus.data_miso_o); end
    @(posedge PCLK); #1;
  endtask

  task automatic test_blocked;
    logic [7:0] txw = 8'hA5;
    logic [7:0] rxw = 8'h81;
    bus.cpol_i = 1'b0; bus.cpha_i = 1'b0;
    start(txw, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        bus.data_mosi_i = 8'h55; bus.lsbfe_i = 1'b1; bus.send_data_i = 1'b1;
        @(posedge PCLK); #1;
        bus.send_data_i = 1'b0;
        checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL bl_busy got=%b exp=1", bus.busy_o); end
      end
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (bus.mosi_o !== txw[7-k]) begin failures++; $display("FAIL bl_mosi bit%0d got=%b exp=%b", k, bus.mosi_o, txw[7-k]); end
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.mosi_o !== 1'b1) begin failures++; $display("FAIL bl_extra_snd got=%b exp=1", bus.mosi_o); end
    for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, rxw[7-k]);
    checks++; if (bus.receive_data_o !== 1'b1) begin failures++; $display("FAIL bl_rcv got=%b exp=1", bus.receive_data_o); end
    checks++; if (bus.data_miso_o !== 8'h81) begin failures++; $display("FAIL bl_data got=%h exp=81", bus.data_miso_o); end
    @(posedge PCLK); #1;
    bus.ss_i = 1'b1; bus.send_data_i = 1'b1;
    @(posedge PCLK); #1;
    bus.send_data_i = 1'b0;
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL bl_ss_busy got=%b exp=0", bus.busy_o); end
    @(posedge PCLK); #1;
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL bl_ss_busy2 got=%b exp=0", bus.busy_o); end
    bus.ss_i = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [7:0] txw = 8'hC3;
    logic [7:0] rxw = 8'h5A;
    bus.cpol_i = 1'b0; bus.cpha_i = 1'b0;
    start(8'hFF, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    #2 PRESET = 1'b1;
    #1;
    checks++; if (bus.mosi_o !== 1'b0) begin failures++; $display("FAIL rm_mosi got=%b exp=0", bus.mosi_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL rm_busy got=%b exp=0", bus.busy_o); end
    checks++; if (bus.receive_data_o !== 1'b0) begin failures++; $display("FAIL rm_rcv got=%b exp=0", bus.receive_data_o); end
    checks++; if (bus.data_miso_o !== 8'h00) begin failures++; $display("FAIL rm_data got=%h exp=00", bus.data_miso_o); end
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    start(txw, 1'b0);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (bus.mosi_o !== txw[7-k]) begin failures++; $display("FAIL rm_mosi bit%0d got=%b exp=%b", k, bus.mosi_o, txw[7-k]); end
      cyc(1'b0, 1'b1, 1'b0, 1'b0, rxw[7-k]);
    end
    checks++; if (bus.receive_data_o !== 1'b1) begin failures++; $display("FAIL rm_rcv_end got=%b exp=1", bus.receive_data_o); end
    checks++; if (bus.data_miso_o !== 8'h5A) begin failures++; $display("FAIL rm_data_end got=%h exp=5a", bus.data_miso_o); end
    @(posedge PCLK); #1;
  endtask

  task automatic test_back_to_back;
    logic [7:0] txw = 8'h6B;
    logic [7:0] rxw = 8'h96;
    bus.cpol_i = 1'b1; bus.cpha_i = 1'b1;
    start(txw, 1'b1);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, rxw[k]);
      checks++; if (bus.mosi_o !== txw[k]) begin failures++; $display("FAIL co_mosi bit%0d got=%b exp=%b", k, bus.mosi_o, txw[k]); end
      checks++; if (bus.receive_data_o !== (k == 7)) begin failures++; $display("FAIL co_rcv bit%0d got=%b exp=%b", k, bus.receive_data_o, (k == 7)); end
    end
    checks++; if (bus.data_miso_o !== 8'h96) begin failures++; $display("FAIL co_data got=%h exp=96", bus.data_miso_o); end
    @(posedge PCLK); #1;
    checks++; if (bus.receive_data_o !== 1'b0) begin failures++; $display("FAIL co_rcv_after got=%b exp=0", bus.receive_data_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL co_busy_after got=%b exp=0", bus.busy_o); end
  endtask

  initial begin
    PRESET                   = 1'b1;
    bus.ss_i                 = 1'b1;
    bus.send_data_i          = 1'b0;
    bus.lsbfe_i              = 1'b0;
    bus.cpol_i               = 1'b0;
    bus.cpha_i               = 1'b0;
    bus.mosi_send_sclk_i     = 1'b0;
    bus.mosi_send_sclk0_i    = 1'b0;
    bus.miso_receive_sclk_i  = 1'b0;
    bus.miso_receive_sclk0_i = 1'b0;
    bus.data_mosi_i          = 8'h00;
    bus.miso_i               = 1'b0;
    test_reset();
    test_msb_mode0();
    test_abort();
    test_lsb_mode10();
    test_blocked();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
